// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset defaults, fetch FSM encoding
// and the IF/ID pipeline slot layout.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StHold  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    localparam int unsigned IFID_WIDTH = $bits(ifid_t);

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline slot register with synchronous reset, load enable and a
// flush that forces only the masked bits to a bubble value.
module ifid_reg #(
    parameter int unsigned      WIDTH       = 97,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] FLUSH_MASK  = '0,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Bits outside FLUSH_MASK keep their value on a flush.
    always_comb begin
        data_d = data_q;
        if (flush) begin
            data_d = (data_q & ~FLUSH_MASK) | (FLUSH_VALUE & FLUSH_MASK);
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch/hold FSM with a one-entry skid
// buffer for responses that arrive while decode is stalled, and the IF/ID slot.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o
);

    localparam ifid_t IFID_RESET = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
    localparam ifid_t IFID_FLUSH_MASK = '{valid: 1'b1, pc: 32'h0, pc4: 32'h0, instr: '1};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;

    logic         ifid_en;
    logic         ifid_flush;
    logic [31:0]  ifid_instr_src;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    // Word alignment drops the low target bits.
    logic         unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        skid_d         = skid_q;
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        ifid_instr_src = imem_rdata_i;

        if (redirect_i) begin
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            skid_d     = '0;
            ifid_flush = 1'b1;
            state_d    = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ready_i) begin
                        if (stall_i) begin
                            skid_d  = imem_rdata_i;
                            state_d = StHold;
                        end else begin
                            ifid_en = 1'b1;
                            pc_d    = pc_inc(pc_q);
                        end
                    end else if (!stall_i) begin
                        ifid_flush = 1'b1;
                    end
                end
                StHold: begin
                    if (!stall_i) begin
                        ifid_en        = 1'b1;
                        ifid_instr_src = skid_q;
                        pc_d           = pc_inc(pc_q);
                        state_d        = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    assign ifid_d = '{valid: 1'b1, pc: pc_q, pc4: pc_inc(pc_q), instr: ifid_instr_src};

    ifid_reg #(
        .WIDTH       (IFID_WIDTH),
        .RESET_VALUE (IFID_RESET),
        .FLUSH_MASK  (IFID_FLUSH_MASK),
        .FLUSH_VALUE (IFID_RESET)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (ifid_en),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_req_o   = (state_q == StFetch);
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = ifid_q.valid;
    assign ifid_pc_o    = ifid_q.pc;
    assign ifid_pc4_o   = ifid_q.pc4;
    assign ifid_instr_o = ifid_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: table of per-cycle inputs and the
// expected state after the following rising edge, plus reset corner cases.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_ready_i  (imem_ready_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] rdata,
                       input logic req, input logic [31:0] addr, input logic v,
                       input logic [31:0] pc, input logic [31:0] pc4,
                       input logic [31:0] instr);
        vec_t x;
        x = '{st, rd, rpc, rdy, rdata, req, addr, v, pc, pc4, instr};
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [31:0] instr);
        n_checks++;
        if (imem_req_o === req && imem_addr_o === addr && ifid_valid_o === v &&
            ifid_pc_o === pc && ifid_pc4_o === pc4 && ifid_instr_o === instr) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got req=%b addr=%h v=%b pc=%h pc4=%h instr=%h, want req=%b addr=%h v=%b pc=%h pc4=%h instr=%h",
                     name, imem_req_o, imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o,
                     ifid_instr_o, req, addr, v, pc, pc4, instr);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic [31:0] rdata);
        @(negedge clk);
        rst           = r;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_ready_i  = rdy;
        imem_rdata_i  = rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_ready_i  = 1'b0;
        imem_rdata_i  = '0;

        // st rd rpc rdy rdata | req addr v pc pc4 instr
        add(0, 0, 0, 1, 32'h8C01_0000, 1, 32'h0040_0004, 1, 32'h0040_0000, 32'h0040_0004, 32'h8C01_0000);
        add(0, 0, 0, 1, 32'h8C02_0004, 1, 32'h0040_0008, 1, 32'h0040_0004, 32'h0040_0008, 32'h8C02_0004);
        add(0, 0, 0, 1, 32'h8C03_0008, 1, 32'h0040_000C, 1, 32'h0040_0008, 32'h0040_000C, 32'h8C03_0008);
        add(1, 1, 32'h11, 1, 32'hFFFF_0000, 1, 32'h10, 0, 32'h0040_0008, 32'h0040_000C, NOP);
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 32'hFFFF_0000, 1, 32'h10, 0, 32'h0040_0008, 32'h0040_000C, NOP);
        add(0, 0, 0, 1, 32'h2108_0001, 1, 32'h14, 1, 32'h10, 32'h14, 32'h2108_0001);
        add(1, 0, 0, 0, 32'h0BAD_0BAD, 1, 32'h14, 1, 32'h10, 32'h14, 32'h2108_0001);
        add(0, 1, 32'h1E, 0, 32'h0BAD_0BAD, 1, 32'h1C, 0, 32'h10, 32'h14, NOP);
        add(0, 0, 0, 1, 32'h1111_2222, 1, 32'h20, 1, 32'h1C, 32'h20, 32'h1111_2222);
        add(1, 0, 0, 1, 32'hAAAA_5555, 0, 32'h20, 1, 32'h1C, 32'h20, 32'h1111_2222);
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 1, 32'h0BAD_0BAD, 0, 32'h20, 1, 32'h1C, 32'h20, 32'h1111_2222);
        add(0, 0, 0, 0, 32'h0BAD_0BAD, 1, 32'h24, 1, 32'h20, 32'h24, 32'hAAAA_5555);
        add(1, 0, 0, 1, 32'hBBBB_BBBB, 0, 32'h24, 1, 32'h20, 32'h24, 32'hAAAA_5555);
        add(1, 1, 32'h103, 1, 32'h0BAD_0BAD, 1, 32'h100, 0, 32'h20, 32'h24, NOP);
        add(0, 0, 0, 1, 32'hCCCC_CCCC, 1, 32'h104, 1, 32'h100, 32'h104, 32'hCCCC_CCCC);
        add(0, 1, 32'hFFFF_FFFF, 0, 32'h0BAD_0BAD, 1, 32'hFFFF_FFFC, 0, 32'h100, 32'h104, NOP);
        add(0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF);
        add(1, 0, 0, 1, 32'h1234_5678, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF);

        // Reset state
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("reset", 1, RST_PC, 0, 32'h0, 32'h0, NOP);

        foreach (vecs[i]) begin
            drive(0, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready, vecs[i].rdata);
            check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                  vecs[i].pc, vecs[i].pc4, vecs[i].instr);
        end

        // Reset while in HOLD beats stall and redirect, and drops the skid entry
        drive(1, 1, 1, 32'h200, 1, 32'h0BAD_0BAD);
        check("rst_in_hold", 1, RST_PC, 0, 32'h0, 32'h0, NOP);
        drive(0, 0, 0, 0, 1, 32'h0000_0055);
        check("post_rst_fetch", 1, RST_PC + 32'd4, 1, RST_PC, RST_PC + 32'd4, 32'h0000_0055);
        drive(0, 1, 0, 0, 0, 32'h0BAD_0BAD);
        drive(0, 0, 0, 0, 0, 32'h0BAD_0BAD);
        check("bubble_after_stall", 1, RST_PC + 32'd4, 0, RST_PC, RST_PC + 32'd4, NOP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
